// File: rtl/seg7_reader.sv
// Receive-side monitor for an active-low 7-segment display bus: waits for the
// pattern to settle, decodes every digit to a nibble and offers the word on valid/ready.
module seg7_reader #(
   parameter int NDIG          = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [6:0]        segments [0:NDIG-1],
   output logic [4*NDIG-1:0] value,
   output logic [NDIG-1:0]   blank_mask,
   output logic [NDIG-1:0]   error_mask,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, SCAN, PRESENT} state_t;

   state_t          state, state_nx;
   logic [6:0]      seg_q [0:NDIG-1];
   logic [6:0]      last  [0:NDIG-1];
   logic [6:0]      snap  [0:NDIG-1];
   logic            first_pending;
   logic [CW-1:0]   stable_cnt;
   logic [IW-1:0]   idx;
   logic            changed, diff_last;
   logic            cnt_clr, cnt_inc, capture, scan_en, accept;
   logic [5:0]      dec;

   // Result layout: {error, blank, nibble}
   function automatic logic [5:0] decode(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'h40: r = 6'h00;  7'h79: r = 6'h01;  7'h24: r = 6'h02;  7'h30: r = 6'h03;
         7'h19: r = 6'h04;  7'h12: r = 6'h05;  7'h02: r = 6'h06;  7'h78: r = 6'h07;
         7'h00: r = 6'h08;  7'h10: r = 6'h09;  7'h08: r = 6'h0A;  7'h03: r = 6'h0B;
         7'h46: r = 6'h0C;  7'h21: r = 6'h0D;  7'h06: r = 6'h0E;  7'h0E: r = 6'h0F;
         7'h7F:   r = 6'b01_0000;
         default: r = 6'b10_0000;
      endcase
      return r;
   endfunction

   always_comb begin
      changed   = 1'b0;
      diff_last = 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (segments[i] != seg_q[i]) changed   = 1'b1;
         if (segments[i] != last[i])  diff_last = 1'b1;
      end
   end

   always_comb dec = decode(snap[idx]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      capture  = 1'b0;
      scan_en  = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (first_pending || diff_last) begin
               cnt_clr  = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (changed) begin
               cnt_clr = 1'b1;
            end else if (stable_cnt == CW'(STABLE_CYCLES - 1)) begin
               capture  = 1'b1;
               state_nx = SCAN;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SCAN: begin
            scan_en = 1'b1;
            if (idx == IW'(NDIG - 1)) state_nx = PRESENT;
         end
         PRESENT: begin
            if (out_ready) begin
               accept   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb out_valid = (state == PRESENT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NDIG; i++) begin
            seg_q[i] <= 7'h7F;
            last[i]  <= 7'h7F;
            snap[i]  <= 7'h7F;
         end
         first_pending <= 1'b1;
         stable_cnt    <= '0;
         idx           <= '0;
         value         <= '0;
         blank_mask    <= '0;
         error_mask    <= '0;
      end else begin
         seg_q <= segments;
         if (cnt_clr)      stable_cnt <= '0;
         else if (cnt_inc) stable_cnt <= stable_cnt + 1'b1;
         // Snapshot comes from seg_q, which equals the live bus once it has been stable
         if (capture) begin
            snap <= seg_q;
            idx  <= '0;
         end
         if (scan_en) begin
            idx <= idx + 1'b1;
            for (int unsigned i = 0; i < NDIG; i++) begin
               if (idx == IW'(i)) begin
                  value[4*i +: 4] <= dec[3:0];
                  blank_mask[i]   <= dec[4];
                  error_mask[i]   <= dec[5];
               end
            end
         end
         if (accept) begin
            last          <= snap;
            first_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: latency, decode, blanking, errors,
// settling, handshake hold and reset abort.
module tb_seg7_reader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  seg [0:7];
   logic [31:0] value;
   logic [7:0]  blank_mask, error_mask;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int compared = 0;
   int mismatched = 0;
   int words = 0;
   int w0;
   int cyc;

   seg7_reader #(.NDIG(8), .STABLE_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .segments   (seg),
      .value      (value),
      .blank_mask (blank_mask),
      .error_mask (error_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      if (!reset && out_valid && out_ready) words <= words + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_all(input logic [6:0] c);
      for (int i = 0; i < 8; i++) seg[i] = c;
   endtask

   // Returns ticks until out_valid; max+1 if it never rose
   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!out_valid && n <= max) begin
         tick();
         n++;
      end
   endtask

   initial begin
      // 1: all zeros through reset release
      set_all(7'h40);
      ticks(3);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_value", 64'(value), 64'h0);
      check("rst_blank", 64'(blank_mask), 64'h0);
      check("rst_error", 64'(error_mask), 64'h0);
      reset = 1'b0;
      w0 = words;
      wait_valid(40, cyc);
      check("t1_latency", 64'(cyc), 64'd13);
      check("t1_value", 64'(value), 64'h0);
      check("t1_blank", 64'(blank_mask), 64'h0);
      check("t1_error", 64'(error_mask), 64'h0);
      tick();
      check("t1_valid_drop", 64'(out_valid), 64'h0);
      ticks(30);
      check("t1_one_word", 64'(words - w0), 64'd1);

      // 2: DEADBEEF held while ready is low
      out_ready = 1'b0;
      seg[7] = 7'h21; seg[6] = 7'h06; seg[5] = 7'h08; seg[4] = 7'h21;
      seg[3] = 7'h03; seg[2] = 7'h06; seg[1] = 7'h06; seg[0] = 7'h0E;
      w0 = words;
      wait_valid(40, cyc);
      check("t2_latency", 64'(cyc), 64'd13);
      for (int k = 0; k < 10; k++) begin
         check("t2_hold_valid", 64'(out_valid), 64'h1);
         check("t2_hold_value", 64'(value), 64'hDEADBEEF);
         tick();
      end
      check("t2_blank", 64'(blank_mask), 64'h0);
      check("t2_error", 64'(error_mask), 64'h0);
      out_ready = 1'b1;
      tick();
      check("t2_valid_drop", 64'(out_valid), 64'h0);
      ticks(20);
      check("t2_one_word", 64'(words - w0), 64'd1);

      // 3: back to zeros, then a bouncing digit 0
      set_all(7'h40);
      wait_valid(40, cyc);
      check("t3_pre_value", 64'(value), 64'h0);
      tick();
      w0 = words;
      for (int k = 0; k < 5; k++) begin
         seg[0] = (k % 2 == 0) ? 7'h79 : 7'h40;
         ticks(2);
      end
      seg[0] = 7'h79;
      wait_valid(60, cyc);
      check("t3_value", 64'(value), 64'h00000001);
      ticks(30);
      check("t3_one_word", 64'(words - w0), 64'd1);

      // 4: upper digits blank
      seg[7] = 7'h7F; seg[6] = 7'h7F; seg[5] = 7'h7F; seg[4] = 7'h7F;
      seg[3] = 7'h79; seg[2] = 7'h24; seg[1] = 7'h30; seg[0] = 7'h19;
      wait_valid(40, cyc);
      check("t4_latency", 64'(cyc), 64'd13);
      check("t4_value", 64'(value), 64'h00001234);
      check("t4_blank", 64'(blank_mask), 64'hF0);
      check("t4_error", 64'(error_mask), 64'h0);
      tick();

      // 5: illegal pattern on digit 2
      set_all(7'h40);
      seg[2] = 7'h55;
      wait_valid(40, cyc);
      check("t5_error", 64'(error_mask), 64'h04);
      check("t5_value", 64'(value), 64'h0);
      check("t5_blank", 64'(blank_mask), 64'h0);
      tick();

      // 6: reset during SCAN idx=3
      set_all(7'h79);
      ticks(8);
      reset = 1'b1;
      #1;
      check("t6_rst_valid", 64'(out_valid), 64'h0);
      check("t6_rst_value", 64'(value), 64'h0);
      check("t6_rst_blank", 64'(blank_mask), 64'h0);
      check("t6_rst_error", 64'(error_mask), 64'h0);
      ticks(2);
      check("t6_rst_hold", 64'(out_valid), 64'h0);
      reset = 1'b0;
      wait_valid(40, cyc);
      check("t6_latency", 64'(cyc), 64'd13);
      check("t6_value", 64'(value), 64'h11111111);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
